// File: rtl/bsg_link_pkg.sv
// Shared constants, FSM state encoding and beat-select helper for the
// upstream link transmitter.
package bsg_link_pkg;

  localparam int CORE_W = 32;
  localparam int LINK_W = 8;
  localparam int BEATS  = 4;

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  // Beat idx of a core word, least-significant byte first.
  function automatic logic [LINK_W-1:0] select_beat(input logic [CORE_W-1:0] word,
                                                    input logic [1:0]        idx);
    select_beat = word[int'(idx)*LINK_W +: LINK_W];
  endfunction

endpackage

// File: rtl/bsg_tx_fifo.sv
// Core-side word buffer: power-of-two depth, extra pointer bit separates
// full from empty.
module bsg_tx_fifo
  import bsg_link_pkg::*;
#(
  parameter int WIDTH = CORE_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Occupancy flags and qualified push/pop strobes.
  always_comb begin
    empty     = (wr_ptr_r == rd_ptr_r);
    full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
    data_out  = mem_r[rd_ptr_r[AW-1:0]];
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= data_in;
    end
  end

  // Read/write pointers wrap naturally through the extra MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/bsg_upstream_tx.sv
// Upstream link transmitter: buffers 32-bit core words and serializes each
// into four byte beats, gated by receiver credits returned as token pulses.
module bsg_upstream_tx
  import bsg_link_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS    = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CORE_W-1:0]              core_data_in,
  input  logic                           core_valid_in,
  output logic                           core_ready_out,
  output logic [LINK_W-1:0]              io_data_out,
  output logic                           io_valid_out,
  input  logic                           io_token_in,
  output logic [$clog2(CREDITS+1)-1:0]   credits_out,
  output logic                           token_err_out
);

  localparam int              CW          = $clog2(CREDITS+1);
  localparam logic [0:0]      ST_IDLE     = TX_IDLE;
  localparam logic [0:0]      ST_SEND     = TX_SEND;
  localparam logic [CW-1:0]   CREDITS_MAX = CW'(CREDITS);
  localparam logic [1:0]      LAST_BEAT   = 2'(BEATS-1);

  logic [0:0]        state_r;
  logic [1:0]        beat_r;
  logic [CORE_W-1:0] word_r;
  logic [LINK_W-1:0] io_data_r;
  logic              io_valid_r;
  logic [CW-1:0]     credits_r;
  logic              token_err_r;

  logic [CORE_W-1:0] fifo_data_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              push_s;
  logic              start_s;
  logic              last_beat_s;
  logic              have_credit_s;
  logic [1:0]        next_beat_s;

  bsg_tx_fifo #(
    .WIDTH (CORE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_s),
    .data_in  (core_data_in),
    .pop      (start_s),
    .data_out (fifo_data_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s)
  );

  // Handshake and word-start decision; a start pops the FIFO and spends a credit.
  always_comb begin
    core_ready_out = !fifo_full_s && !rst;
    push_s         = core_valid_in && core_ready_out;
    have_credit_s  = (credits_r != {CW{1'b0}});
    last_beat_s    = (state_r == ST_SEND) && (beat_r == LAST_BEAT);
    next_beat_s    = beat_r + 2'd1;
    start_s        = !fifo_empty_s && have_credit_s &&
                     ((state_r == ST_IDLE) || last_beat_s);
  end

  // FSM and serializer; beat_r names the beat currently on the link.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      beat_r     <= 2'd0;
      word_r     <= {CORE_W{1'b0}};
      io_data_r  <= {LINK_W{1'b0}};
      io_valid_r <= 1'b0;
    end else if (start_s) begin
      state_r    <= ST_SEND;
      beat_r     <= 2'd0;
      word_r     <= fifo_data_s;
      io_data_r  <= select_beat(fifo_data_s, 2'd0);
      io_valid_r <= 1'b1;
    end else if ((state_r == ST_SEND) && !last_beat_s) begin
      beat_r     <= next_beat_s;
      io_data_r  <= select_beat(word_r, next_beat_s);
      io_valid_r <= 1'b1;
    end else if (state_r == ST_SEND) begin
      // Last beat sent and nothing eligible to follow: idle, data held.
      state_r    <= ST_IDLE;
      beat_r     <= 2'd0;
      io_valid_r <= 1'b0;
    end else begin
      io_valid_r <= 1'b0;
    end
  end

  // Credit counter; an overflowing token is dropped and flagged stickily.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits_r   <= CREDITS_MAX;
      token_err_r <= 1'b0;
    end else if (io_token_in && !start_s) begin
      if (credits_r == CREDITS_MAX) begin
        token_err_r <= 1'b1;
      end else begin
        credits_r <= credits_r + CW'(1);
      end
    end else if (start_s && !io_token_in) begin
      credits_r <= credits_r - CW'(1);
    end else begin
      credits_r <= credits_r;
    end
  end

  assign io_data_out   = io_data_r;
  assign io_valid_out  = io_valid_r;
  assign credits_out   = credits_r;
  assign token_err_out = token_err_r;

endmodule

// File: tb/tb_bsg_upstream_tx.sv
// Directed bench for bsg_upstream_tx with a byte scoreboard checked on the
// falling clock edge.
module tb_bsg_upstream_tx;

  logic        clk;
  logic        rst;
  logic [31:0] core_data_in;
  logic        core_valid_in;
  logic        core_ready_out;
  logic [7:0]  io_data_out;
  logic        io_valid_out;
  logic        io_token_in;
  logic [3:0]  credits_out;
  logic        token_err_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int beat_cnt = 0;
  int first_cyc = 0;
  int last_cyc  = 0;
  bit mark_first = 1'b0;
  logic [7:0] exp_q[$];

  bsg_upstream_tx #(.FIFO_DEPTH(4), .CREDITS(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .core_data_in   (core_data_in),
    .core_valid_in  (core_valid_in),
    .core_ready_out (core_ready_out),
    .io_data_out    (io_data_out),
    .io_valid_out   (io_valid_out),
    .io_token_in    (io_token_in),
    .credits_out    (credits_out),
    .token_err_out  (token_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every valid beat must match the next expected byte.
  always @(negedge clk) begin
    if (io_valid_out) begin
      logic [7:0] e;
      beat_cnt = beat_cnt + 1;
      if (mark_first) begin
        first_cyc  = cyc;
        mark_first = 1'b0;
      end
      last_cyc = cyc;
      total = total + 1;
      if (exp_q.size() == 0) begin
        assert (1'b0) else begin
          bad = bad + 1;
          $error("FAIL unexpected_beat observed=%h expected=none", io_data_out);
        end
      end else begin
        e = exp_q.pop_front();
        assert (io_data_out === e) else begin
          bad = bad + 1;
          $error("FAIL beat_data observed=%h expected=%h", io_data_out, e);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] w);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[31:24]);
  endtask

  task automatic push_word(input logic [31:0] w);
    int n;
    n = 0;
    core_data_in  = w;
    core_valid_in = 1'b1;
    while (!core_ready_out && n < 200) begin
      tick();
      n++;
    end
    chk("push_wait", 32'(n < 200), 32'd1);
    push_exp(w);
    tick();
    core_valid_in = 1'b0;
  endtask

  task automatic token_pulse();
    io_token_in = 1'b1;
    tick();
    io_token_in = 1'b0;
  endtask

  task automatic wait_drain(input int keep);
    int n;
    n = 0;
    while ((exp_q.size() > keep || io_valid_out) && n < 500) begin
      tick();
      n++;
    end
    chk("drain_wait", 32'(n < 500), 32'd1);
  endtask

  initial begin
    int b0;
    rst           = 1'b1;
    core_data_in  = 32'h0;
    core_valid_in = 1'b0;
    io_token_in   = 1'b0;
    tick();
    tick();
    chk("ready_in_reset", 32'(core_ready_out), 32'd0);
    chk("rst_valid", 32'(io_valid_out), 32'd0);
    chk("rst_data", 32'(io_data_out), 32'h00);
    chk("rst_credits", 32'(credits_out), 32'd8);
    chk("rst_err", 32'(token_err_out), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 32'(core_ready_out), 32'd1);

    // Single word: minimum latency and byte order.
    b0 = beat_cnt;
    push_word(32'hDEADBEEF);
    chk("t1_no_beat_yet", 32'(io_valid_out), 32'd0);
    tick();
    chk("t1_beat0_valid", 32'(io_valid_out), 32'd1);
    chk("t1_beat0_data", 32'(io_data_out), 32'hEF);
    chk("t1_credits", 32'(credits_out), 32'd7);
    wait_drain(0);
    chk("t1_beats", 32'(beat_cnt - b0), 32'd4);
    token_pulse();
    chk("t1_credit_back", 32'(credits_out), 32'd8);

    // Three back-to-back words: 12 contiguous beats.
    b0 = beat_cnt;
    mark_first = 1'b1;
    chk("t2_ready0", 32'(core_ready_out), 32'd1);
    push_word(32'h11223344);
    chk("t2_ready1", 32'(core_ready_out), 32'd1);
    push_word(32'h55667788);
    chk("t2_ready2", 32'(core_ready_out), 32'd1);
    push_word(32'h99AABBCC);
    chk("t2_ready3", 32'(core_ready_out), 32'd1);
    wait_drain(0);
    chk("t2_beats", 32'(beat_cnt - b0), 32'd12);
    chk("t2_contiguous", 32'(last_cyc - first_cyc), 32'd11);
    chk("t2_credits", 32'(credits_out), 32'd5);

    // Token coincident with a start at credits=5, then overflow token.
    push_word(32'hCAFEF00D);
    io_token_in = 1'b1;
    tick();
    io_token_in = 1'b0;
    chk("t3_started", 32'(io_valid_out), 32'd1);
    chk("t3_credits_same", 32'(credits_out), 32'd5);
    wait_drain(0);
    token_pulse();
    token_pulse();
    token_pulse();
    chk("t3_credits_full", 32'(credits_out), 32'd8);
    chk("t3_no_err_yet", 32'(token_err_out), 32'd0);
    token_pulse();
    chk("t3_credits_cap", 32'(credits_out), 32'd8);
    chk("t3_err_set", 32'(token_err_out), 32'd1);

    // Nine words with no tokens: eight go, ninth waits for a credit.
    b0 = beat_cnt;
    for (int i = 0; i < 9; i++) begin
      push_word(32'hA0B0C000 + 32'(i));
    end
    wait_drain(4);
    chk("t4_beats", 32'(beat_cnt - b0), 32'd32);
    chk("t4_credits_zero", 32'(credits_out), 32'd0);
    tick();
    tick();
    tick();
    chk("t4_held", 32'(io_valid_out), 32'd0);
    chk("t4_ready_a", 32'(core_ready_out), 32'd1);
    push_word(32'h0000000A);
    chk("t4_ready_b", 32'(core_ready_out), 32'd1);
    push_word(32'h0000000B);
    chk("t4_ready_c", 32'(core_ready_out), 32'd1);
    push_word(32'h0000000C);
    chk("t4_ready_full", 32'(core_ready_out), 32'd0);
    token_pulse();
    chk("t4_token_idle", 32'(io_valid_out), 32'd0);
    chk("t4_credit_one", 32'(credits_out), 32'd1);
    tick();
    chk("t4_ninth_start", 32'(io_valid_out), 32'd1);
    chk("t4_ninth_byte0", 32'(io_data_out), 32'h08);
    chk("t4_credit_used", 32'(credits_out), 32'd0);
    chk("t4_ready_again", 32'(core_ready_out), 32'd1);
    for (int i = 0; i < 3; i++) begin
      token_pulse();
      tick();
    end
    wait_drain(0);
    chk("t4_credits_spent", 32'(credits_out), 32'd0);
    for (int i = 0; i < 8; i++) begin
      token_pulse();
    end
    chk("t4_credits_back", 32'(credits_out), 32'd8);
    chk("t4_err_sticky", 32'(token_err_out), 32'd1);

    // Reset during beat 2 of a word with two words queued.
    b0 = beat_cnt;
    push_word(32'h01234567);
    push_word(32'h89ABCDEF);
    push_word(32'h13579BDF);
    chk("t5_beat1", 32'(io_data_out), 32'h45);
    tick();
    chk("t5_beat2", 32'(io_data_out), 32'h23);
    rst = 1'b1;
    tick();
    exp_q.delete();
    chk("t5_beats_before", 32'(beat_cnt - b0), 32'd3);
    chk("t5_valid", 32'(io_valid_out), 32'd0);
    chk("t5_data", 32'(io_data_out), 32'h00);
    chk("t5_credits", 32'(credits_out), 32'd8);
    chk("t5_err", 32'(token_err_out), 32'd0);
    chk("t5_ready_rst", 32'(core_ready_out), 32'd0);
    rst = 1'b0;
    #1;
    chk("t5_ready_after", 32'(core_ready_out), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
    end
    chk("t5_no_more_beats", 32'(beat_cnt - b0), 32'd3);
    push_word(32'hC0FFEE11);
    wait_drain(0);
    chk("t5_resume_beats", 32'(beat_cnt - b0), 32'd7);
    chk("t5_resume_credits", 32'(credits_out), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bsg_upstream_tx.md
BSG_UPSTREAM_TX -- requirements
Module: bsg_upstream_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, sets the number of 32-bit words buffered on the core side (power of two, minimum 2).
REQ-002 Parameter CREDITS, default 8, sets the number of words the far-end receiver can hold, which is also the reset credit count.
REQ-003 clk  input  1  the single clock; all logic is clocked on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 core_data_in  input  32  word from the core.
REQ-006 core_valid_in  input  1  core_data_in is valid.
REQ-007 core_ready_out  output  1  the block accepts a word this cycle.
REQ-008 io_data_out  output  8  link byte, registered.
REQ-009 io_valid_out  output  1  io_data_out is valid, registered.
REQ-010 io_token_in  input  1  one-cycle pulse from the receiver returning one word credit.
REQ-011 credits_out  output  $clog2(CREDITS+1)  current credit count.
REQ-012 token_err_out  output  1  sticky flag: a token was returned while credits were already at CREDITS.

Function
REQ-013 A word SHALL be accepted when core_valid_in & core_ready_out; core_ready_out = FIFO not full, with no dependence on a pop in the same cycle.
REQ-014 Each word SHALL be sent as 4 consecutive beats, in the order bits [7:0], [15:8], [23:16], [31:24], with io_valid_out=1 on every beat.
REQ-015 FSM states: IDLE and SEND; a 2-bit beat counter runs 0..3 while in SEND.
REQ-016 IDLE->SEND when the FIFO is non-empty and credits>0; the word is popped and one credit is consumed on the edge that registers beat 0.
REQ-017 SEND at beat 3: if the FIFO is non-empty and credits>0, the next word's beat 0 follows on the next cycle with no gap; otherwise the FSM returns to IDLE.
REQ-018 io_valid_out SHALL be 0 and io_data_out SHALL hold its last value while in IDLE.
REQ-019 Minimum latency: a word accepted at edge t drives its beat 0 on the outputs after edge t+1, provided the FIFO was empty and credits>0.
REQ-020 With credits=0, the block SHALL NOT start a word; a word already in progress completes all 4 beats.
REQ-021 A token with no start in the same cycle SHALL give credits+1.
REQ-022 A start with no token in the same cycle SHALL give credits-1.
REQ-023 A token and a start in the same cycle SHALL leave credits unchanged.
REQ-024 A token at credits=CREDITS with no start SHALL leave credits unchanged and set token_err_out, which stays set until reset.
REQ-025 A push to a full FIFO is impossible because core_ready_out=0; a push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-026 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty are distinguished by an extra pointer bit.

Reset
REQ-027 When rst=1 at an edge, the following SHALL hold on that edge: FSM=IDLE, beat counter=0, FIFO empty, credits_out=CREDITS, io_valid_out=0, io_data_out=8'h00, token_err_out=0.
REQ-028 core_ready_out SHALL be 0 while rst=1 and 1 on the first cycle after reset.
REQ-029 A reset asserted mid-word SHALL abort the word (no further beats), discard all buffered words, and restore the credits without requiring tokens.

Structure
REQ-030 Package bsg_link_pkg SHALL hold CORE_W=32, LINK_W=8, BEATS=4, and the tx_state_e enum {TX_IDLE, TX_SEND}.
REQ-031 The FIFO SHALL be the sub-module bsg_tx_fifo (width, depth parameters; push/pop/full/empty).
REQ-032 The FSM, serializer and credit counter SHALL be implemented in bsg_upstream_tx.

Verification
REQ-033 Reset, then push 32'hDEADBEEF -> bytes EF, BE, AD, DE with io_valid_out=1 on 4 consecutive cycles, starting 2 edges after the push; credits_out 8->7.
REQ-034 Push 9 words with no tokens -> 8 words sent (32 beats); the 9th word is held, io_valid_out=0 and credits_out=0; one io_token_in pulse -> the 9th word starts on the following cycle.
REQ-035 Push 3 words back to back with credits available -> 12 contiguous valid beats with no idle cycle; core_ready_out falls only when 4 words are buffered.
REQ-036 io_token_in pulsed on the same cycle as a word start with credits=5 -> credits_out stays 5; a token at credits=8 while idle -> credits stay 8 and token_err_out=1.
REQ-037 rst asserted during beat 2 of 32'h01234567 with 2 words queued -> no further beats, FIFO empty, credits_out=8, token_err_out=0, and normal sending resumes after reset.
